// File: rtl/sfx_sequencer.sv
// Event-driven sound-effect player for the piezo buzzer: three prioritised note-sequence
// channels (flap, score, game-over) with game-over lockout, mute and status outputs.
module sfx_sequencer #(
  parameter int unsigned              DIV_W       = 18,
  parameter int unsigned              TICK_W      = 25,
  parameter int unsigned              SEQ_MAX     = 4,
  parameter logic [SEQ_MAX*DIV_W-1:0] FLAP_SEQ    = {{3{18'd0}}, 18'd95420},
  parameter logic [SEQ_MAX*DIV_W-1:0] SCORE_SEQ   = {{2{18'd0}}, 18'd50607, 18'd63775},
  parameter logic [SEQ_MAX*DIV_W-1:0] OVER_SEQ    = {18'd95420, 18'd75757, 18'd63775, 18'd50607},
  parameter int unsigned              FLAP_LEN    = 1,
  parameter int unsigned              SCORE_LEN   = 2,
  parameter int unsigned              OVER_LEN    = 4,
  parameter logic [TICK_W-1:0]        FLAP_TICKS  = 25'd2499999,
  parameter logic [TICK_W-1:0]        SCORE_TICKS = 25'd4999999,
  parameter logic [TICK_W-1:0]        OVER_TICKS  = 25'd12499999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       flap_trig,
  input  logic       score_trig,
  input  logic       over_trig,
  input  logic       mute,
  output logic       beep,
  output logic       busy,
  output logic [1:0] cur_eff,
  output logic [1:0] note_idx
);

  if (SEQ_MAX < 1 || SEQ_MAX > 4) begin : g_bad_seq_max
    $error("sfx_sequencer: SEQ_MAX must be 1..4 (note_idx is 2 bits)");
  end
  if (FLAP_LEN < 1 || FLAP_LEN > SEQ_MAX) begin : g_bad_flap_len
    $error("sfx_sequencer: FLAP_LEN out of range 1..SEQ_MAX");
  end
  if (SCORE_LEN < 1 || SCORE_LEN > SEQ_MAX) begin : g_bad_score_len
    $error("sfx_sequencer: SCORE_LEN out of range 1..SEQ_MAX");
  end
  if (OVER_LEN < 1 || OVER_LEN > SEQ_MAX) begin : g_bad_over_len
    $error("sfx_sequencer: OVER_LEN out of range 1..SEQ_MAX");
  end

  typedef enum logic {S_IDLE, S_PLAY} state_t;
  // Effect codes double as priority levels, so "priority >= current" is a plain compare.
  typedef enum logic [1:0] {EFF_NONE = 2'd0, EFF_FLAP = 2'd1, EFF_SCORE = 2'd2, EFF_OVER = 2'd3} eff_t;

  state_t             state_q, state_d;
  eff_t               eff_q, eff_d, win_eff;
  logic [1:0]         idx_q, idx_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]   div_val_q, div_val_d;
  logic               beep_q, beep_d;
  logic               flap_d_q, score_d_q, over_d_q;
  logic               arm_q;
  logic               flap_req, score_req, over_req, start;

  function automatic logic [DIV_W-1:0] seq_note(input eff_t eff, input logic [1:0] idx);
    logic [DIV_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < SEQ_MAX; i++) begin
      if (2'(i) == idx) begin
        case (eff)
          EFF_FLAP:  n = FLAP_SEQ[i*DIV_W +: DIV_W];
          EFF_SCORE: n = SCORE_SEQ[i*DIV_W +: DIV_W];
          EFF_OVER:  n = OVER_SEQ[i*DIV_W +: DIV_W];
          default:   n = '0;
        endcase
      end
    end
    return n;
  endfunction

  function automatic logic [TICK_W-1:0] eff_ticks(input eff_t eff);
    case (eff)
      EFF_FLAP:  return FLAP_TICKS;
      EFF_SCORE: return SCORE_TICKS;
      EFF_OVER:  return OVER_TICKS;
      default:   return '0;
    endcase
  endfunction

  function automatic logic [1:0] eff_last(input eff_t eff);
    case (eff)
      EFF_FLAP:  return 2'(FLAP_LEN - 1);
      EFF_SCORE: return 2'(SCORE_LEN - 1);
      EFF_OVER:  return 2'(OVER_LEN - 1);
      default:   return '0;
    endcase
  endfunction

  // arm_q keeps a trigger that is already high at reset release from counting as an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flap_d_q  <= 1'b0;
      score_d_q <= 1'b0;
      over_d_q  <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      flap_d_q  <= flap_trig;
      score_d_q <= score_trig;
      over_d_q  <= over_trig;
      arm_q     <= 1'b1;
    end
  end

  always_comb begin
    flap_req  = arm_q & flap_trig  & ~flap_d_q;
    score_req = arm_q & score_trig & ~score_d_q;
    over_req  = arm_q & over_trig  & ~over_d_q;
    win_eff   = EFF_NONE;
    if (over_req)                     win_eff = EFF_OVER;
    else if (score_req && !over_trig) win_eff = EFF_SCORE;
    else if (flap_req && !over_trig)  win_eff = EFF_FLAP;
    start = (win_eff != EFF_NONE) && (win_eff >= eff_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      eff_q     <= EFF_NONE;
      idx_q     <= '0;
      tick_q    <= '0;
      div_cnt_q <= '0;
      div_val_q <= '0;
      beep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      eff_q     <= eff_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      div_cnt_q <= div_cnt_d;
      div_val_q <= div_val_d;
      beep_q    <= beep_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    eff_d     = eff_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    div_cnt_d = div_cnt_q;
    div_val_d = div_val_q;
    beep_d    = (div_val_q != '0) && !mute && (div_cnt_q >= (div_val_q >> 1));

    if (start) begin
      state_d   = S_PLAY;
      eff_d     = win_eff;
      idx_d     = '0;
      tick_d    = '0;
      div_cnt_d = '0;
      div_val_d = seq_note(win_eff, 2'd0);
    end else if (state_q == S_PLAY) begin
      if (tick_q == eff_ticks(eff_q)) begin
        tick_d    = '0;
        div_cnt_d = '0;
        if (idx_q == eff_last(eff_q)) begin
          state_d   = S_IDLE;
          eff_d     = EFF_NONE;
          idx_d     = '0;
          div_val_d = '0;
        end else begin
          idx_d     = idx_q + 2'd1;
          div_val_d = seq_note(eff_q, idx_q + 2'd1);
        end
      end else begin
        tick_d    = tick_q + 1'b1;
        div_cnt_d = (div_cnt_q >= div_val_q) ? '0 : div_cnt_q + 1'b1;
      end
    end
  end

  assign beep     = beep_q;
  assign busy     = (state_q == S_PLAY);
  assign cur_eff  = eff_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer with shortened notes: directed vector table, hand-written
// corner sequences and randomized triggers against an elapsed-time reference model.
module tb_sfx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flap_trig, score_trig, over_trig, mute;
  logic       beep, busy;
  logic [1:0] cur_eff, note_idx;

  always #5 clk = ~clk;

  sfx_sequencer #(
    .DIV_W      (18),
    .TICK_W     (25),
    .SEQ_MAX    (4),
    .FLAP_SEQ   ({{3{18'd0}}, 18'd9}),
    .SCORE_SEQ  ({{2{18'd0}}, 18'd4, 18'd9}),
    .OVER_SEQ   ({18'd6, 18'd0, 18'd3, 18'd8}),
    .FLAP_LEN   (1),
    .SCORE_LEN  (2),
    .OVER_LEN   (4),
    .FLAP_TICKS (25'd99),
    .SCORE_TICKS(25'd49),
    .OVER_TICKS (25'd29)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .flap_trig (flap_trig),
    .score_trig(score_trig),
    .over_trig (over_trig),
    .mute      (mute),
    .beep      (beep),
    .busy      (busy),
    .cur_eff   (cur_eff),
    .note_idx  (note_idx)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: an effect is described only by its code and the clocks elapsed since
  // it started; note index, tone phase and end of effect follow arithmetically.
  int seqm [1:3][0:3] = '{'{9, 0, 0, 0}, '{9, 4, 0, 0}, '{8, 3, 0, 6}};
  int lenm [1:3]      = '{1, 2, 4};
  int tkm  [1:3]      = '{99, 49, 29};

  int   m_eff, m_e;
  logic m_beep, m_armed, pf, ps, po;

  function automatic logic model_beep(input int eff, input int e, input logic mu);
    int d, p;
    if (eff == 0) return 1'b0;
    d = seqm[eff][e / (tkm[eff] + 1)];
    p = e % (tkm[eff] + 1);
    return (d != 0) && !mu && ((p % (d + 1)) >= (d / 2));
  endfunction

  function automatic int model_win(input logic armed, input logic f, input logic s, input logic o,
                                   input logic fp, input logic sp, input logic op);
    if (armed && o && !op) return 3;
    if (armed && s && !sp && !o) return 2;
    if (armed && f && !fp && !o) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_eff <= 0; m_e <= 0; m_beep <= 1'b0; m_armed <= 1'b0;
      pf <= 1'b0; ps <= 1'b0; po <= 1'b0;
    end else begin
      int w;
      w = model_win(m_armed, flap_trig, score_trig, over_trig, pf, ps, po);
      m_beep <= model_beep(m_eff, m_e, mute);
      if (w != 0 && w >= m_eff) begin
        m_eff <= w;
        m_e   <= 0;
      end else if (m_eff != 0) begin
        if (m_e + 1 == lenm[m_eff] * (tkm[m_eff] + 1)) begin
          m_eff <= 0;
          m_e   <= 0;
        end else begin
          m_e <= m_e + 1;
        end
      end
      pf <= flap_trig; ps <= score_trig; po <= over_trig;
      m_armed <= 1'b1;
    end
  end

  typedef struct {
    logic       f, s, o, m;
    int         n;
    logic       busy;
    logic [1:0] eff;
    logic [1:0] idx;
    logic       beep;
  } vec_t;

  vec_t vt [16];

  initial begin
    int hi, bz;
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 2'd1, 2'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,  99, 1'b1, 2'd1, 2'd0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 1'b1, 2'd2, 2'd0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,  50, 1'b1, 2'd2, 2'd1, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0,   1, 1'b1, 2'd2, 2'd1, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0,   1, 1'b1, 2'd3, 2'd0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 1'b1, 2'd3, 2'd0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b0,   1, 1'b1, 2'd3, 2'd0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 118, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0,   1, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0,   1, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 1'b1, 2'd1, 2'd0, 1'b0};

    rst_n = 1'b0; flap_trig = 1'b0; score_trig = 1'b0; over_trig = 1'b0; mute = 1'b0;
    #12;
    chk("rst_beep", beep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eff",  cur_eff, 0);
    chk("rst_idx",  note_idx, 0);
    #10 rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 16; i++) begin
      flap_trig = vt[i].f; score_trig = vt[i].s; over_trig = vt[i].o; mute = vt[i].m;
      tick(vt[i].n);
      chk($sformatf("vec%0d_busy", i), busy,     vt[i].busy);
      chk($sformatf("vec%0d_eff", i),  cur_eff,  vt[i].eff);
      chk($sformatf("vec%0d_idx", i),  note_idx, vt[i].idx);
      chk($sformatf("vec%0d_beep", i), beep,     vt[i].beep);
    end
    flap_trig = 1'b0; score_trig = 1'b0; over_trig = 1'b0;
    tick(110);

    // Muted flap: silent but full-length.
    mute = 1'b1; flap_trig = 1'b1;
    tick(1);
    chk("mute_start_busy", busy, 1);
    hi = 0; bz = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      hi += int'(beep);
      bz += int'(busy);
    end
    chk("mute_beep_cnt", hi, 0);
    chk("mute_busy_cnt", bz, 99);

    // Unmuted flap: divider 9 gives 6 high clocks out of every 10.
    flap_trig = 1'b0; mute = 1'b0;
    tick(2);
    flap_trig = 1'b1;
    tick(1);
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      hi += int'(beep);
    end
    chk("flap_high_cnt", hi, 60);
    chk("flap_done_busy", busy, 0);
    flap_trig = 1'b0;
    tick(5);

    // Asynchronous reset during game-over note 1; trigger held across release must not fire.
    over_trig = 1'b1;
    tick(36);
    chk("over_note1_idx", note_idx, 1);
    chk("over_note1_eff", cur_eff, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_eff",  cur_eff, 0);
    chk("async_rst_idx",  note_idx, 0);
    chk("async_rst_beep", beep, 0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_no_fire", busy, 0);
    over_trig = 1'b0;
    tick(2);
    over_trig = 1'b1;
    tick(1);
    chk("over_replay_eff", cur_eff, 3);
    over_trig = 1'b0;
    tick(130);

    // Randomized triggers, mute and occasional resets against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39, 0) == 0)  flap_trig  = ~flap_trig;
      if ($urandom_range(79, 0) == 0)  score_trig = ~score_trig;
      if ($urandom_range(299, 0) == 0) over_trig  = ~over_trig;
      if ($urandom_range(49, 0) == 0)  mute       = ~mute;
      if ($urandom_range(999, 0) == 0) begin
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick(1);
      chk("rnd_busy", busy,     (m_eff != 0));
      chk("rnd_eff",  cur_eff,  m_eff);
      chk("rnd_idx",  note_idx, (m_eff != 0) ? m_e / (tkm[m_eff] + 1) : 0);
      chk("rnd_beep", beep,     m_beep);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
